// File: rtl/nibble_mult_seq_ctrl.sv
// Sequential wide unsigned multiplier that reuses one 4x4 combinational core,
// accumulating one shifted nibble partial product per clock between valid/ready ports.

module multiplier_4bits_version10 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product
);
  assign product = {4'b0000, a} * {4'b0000, b};
endmodule

module nibble_mult_seq_ctrl #(
  parameter int N_NIB = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*N_NIB-1:0]     in_a,
  input  logic [4*N_NIB-1:0]     in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*N_NIB-1:0]     out_product,
  output logic                   busy,
  output logic [CNT_W-1:0]       done_count
);
  localparam int WIDTH = 4 * N_NIB;
  localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NIB - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, next_state;
  logic [WIDTH-1:0]     a_reg, b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [IDX_W-1:0]     i, j;
  logic [IDX_W:0]       ij_sum;
  logic [3:0]           a_nib, b_nib;
  logic [7:0]           pp;
  logic [2*WIDTH-1:0]   term, sum;
  logic                 last_term;

  assign a_nib     = a_reg[{i, 2'b00} +: 4];
  assign b_nib     = b_reg[{j, 2'b00} +: 4];
  assign ij_sum    = {1'b0, i} + {1'b0, j};
  assign term      = (2*WIDTH)'(pp) << {ij_sum, 2'b00};
  assign sum       = acc + term;
  assign last_term = (i == LAST) && (j == LAST);

  multiplier_4bits_version10 u_core (
    .a       (a_nib),
    .b       (b_nib),
    .product (pp)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)  next_state = CALC;
        CALC:    if (last_term) next_state = DONE;
        DONE:    if (out_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Flush clears the in-flight work but leaves the result register and counter alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      i           <= '0;
      j           <= '0;
      out_product <= '0;
      done_count  <= '0;
    end else if (flush) begin
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        CALC: begin
          acc <= sum;
          if (j == LAST) begin
            j <= '0;
            i <= last_term ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
          if (last_term) out_product <= sum;
        end
        DONE: begin
          if (out_ready) done_count <= done_count + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_mult_seq_ctrl.sv
// Directed bench for nibble_mult_seq_ctrl: a 2-nibble and a 1-nibble instance,
// expected products and latencies worked out by hand or by a plain multiply.

module tb_nibble_mult_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-nibble instance
  logic        rst_n2, flush2, in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [7:0]  in_a2, in_b2;
  logic [15:0] out_product2, done_count2;

  // 1-nibble instance
  logic        rst_n1, flush1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [3:0]  in_a1, in_b1;
  logic [7:0]  out_product1;
  logic [15:0] done_count1;

  int vectors = 0;
  int miscompares = 0;

  nibble_mult_seq_ctrl #(.N_NIB(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n2), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_product(out_product2), .busy(busy2), .done_count(done_count2)
  );

  nibble_mult_seq_ctrl #(.N_NIB(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n1), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_product(out_product1), .busy(busy1), .done_count(done_count1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid2(output int n);
    n = 0;
    while (out_valid2 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid1(output int n);
    n = 0;
    while (out_valid1 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Present one operand pair to dut2 for one edge, then count edges to out_valid.
  task automatic start2(input logic [7:0] a, input logic [7:0] b, output int lat);
    in_a2 = a;
    in_b2 = b;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    in_a2 = 8'h99;
    in_b2 = 8'h66;
    wait_valid2(lat);
  endtask

  initial begin
    int lat;
    logic [3:0] ra, rb;
    logic [7:0] rexp;

    rst_n2 = 1'b0; flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; in_a2 = '0; in_b2 = '0;
    rst_n1 = 1'b0; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1; in_a1 = '0; in_b1 = '0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready2), 32'd1);
    check("rst_out_valid", 32'(out_valid2), 32'd0);
    check("rst_product", 32'(out_product2), 32'h0);
    check("rst_done_count", 32'(done_count2), 32'd0);
    check("rst_busy", 32'(busy2), 32'd0);
    tick();
    rst_n2 = 1'b1;
    rst_n1 = 1'b1;
    tick();

    // 0x12 * 0x34 = 0x03A8, four edges after accept
    start2(8'h12, 8'h34, lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_product", 32'(out_product2), 32'h03A8);
    check("t1_in_ready_done", 32'(in_ready2), 32'd0);
    tick();
    check("t1_out_valid_drop", 32'(out_valid2), 32'd0);
    check("t1_in_ready_back", 32'(in_ready2), 32'd1);
    check("t1_done_count", 32'(done_count2), 32'd1);

    // 0xFF * 0xFF, then 0x00 * 0xB7 offered while the first result is in DONE
    start2(8'hFF, 8'hFF, lat);
    check("t2_latency", 32'(lat), 32'd4);
    check("t2_product", 32'(out_product2), 32'hFE01);
    in_a2 = 8'h00; in_b2 = 8'hB7; in_valid2 = 1'b1;
    tick();
    check("t2_no_bypass_busy", 32'(busy2), 32'd0);
    check("t2_no_bypass_ready", 32'(in_ready2), 32'd1);
    tick();
    in_valid2 = 1'b0;
    wait_valid2(lat);
    check("t3_latency", 32'(lat), 32'd4);
    check("t3_product_zero", 32'(out_product2), 32'h0000);
    tick();
    check("t3_done_count", 32'(done_count2), 32'd3);

    // Backpressure: 0xA5 * 0x5A = 0x3A02 held for 10 cycles
    out_ready2 = 1'b0;
    start2(8'hA5, 8'h5A, lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 10; k++) begin
      in_a2 = 8'(k * 17);
      in_valid2 = 1'b1;
      tick();
      check("bp_out_valid", 32'(out_valid2), 32'd1);
      check("bp_product", 32'(out_product2), 32'h3A02);
      check("bp_in_ready", 32'(in_ready2), 32'd0);
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid2), 32'd0);
    check("bp_done_count", 32'(done_count2), 32'd4);

    // Flush on the second CALC cycle of 0xFF * 0xFF
    in_a2 = 8'hFF; in_b2 = 8'hFF; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    flush2 = 1'b1;
    tick();
    flush2 = 1'b0;
    check("fl_in_ready", 32'(in_ready2), 32'd1);
    check("fl_busy", 32'(busy2), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("fl_no_valid", 32'(out_valid2), 32'd0);
      tick();
    end
    check("fl_done_count", 32'(done_count2), 32'd4);
    check("fl_product_kept", 32'(out_product2), 32'h3A02);
    // flush beats in_valid on the same edge
    flush2 = 1'b1; in_valid2 = 1'b1; in_a2 = 8'h77; in_b2 = 8'h77;
    tick();
    flush2 = 1'b0; in_valid2 = 1'b0;
    check("fl_priority_idle", 32'(busy2), 32'd0);
    start2(8'h03, 8'h05, lat);
    check("fl_next_latency", 32'(lat), 32'd4);
    check("fl_next_product", 32'(out_product2), 32'h000F);
    tick();
    check("fl_next_count", 32'(done_count2), 32'd5);

    // Async reset in CALC
    in_a2 = 8'h12; in_b2 = 8'h34; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    #2 rst_n2 = 1'b0;
    #1;
    check("ar_calc_out_valid", 32'(out_valid2), 32'd0);
    check("ar_calc_product", 32'(out_product2), 32'h0);
    check("ar_calc_count", 32'(done_count2), 32'd0);
    check("ar_calc_in_ready", 32'(in_ready2), 32'd1);
    #1 rst_n2 = 1'b1;
    @(negedge clk);
    start2(8'h03, 8'h05, lat);
    check("ar_mid_product", 32'(out_product2), 32'h000F);
    tick();
    check("ar_mid_count", 32'(done_count2), 32'd1);

    // Async reset in DONE with out_ready low
    out_ready2 = 1'b0;
    start2(8'hA5, 8'h5A, lat);
    check("ar_done_reached", 32'(out_valid2), 32'd1);
    #2 rst_n2 = 1'b0;
    #1;
    check("ar_done_out_valid", 32'(out_valid2), 32'd0);
    check("ar_done_product", 32'(out_product2), 32'h0);
    check("ar_done_count", 32'(done_count2), 32'd0);
    check("ar_done_in_ready", 32'(in_ready2), 32'd1);
    #1 rst_n2 = 1'b1;
    out_ready2 = 1'b1;
    @(negedge clk);

    // N_NIB = 1: 0xF * 0xF = 0xE1 one edge after accept
    in_a1 = 4'hF; in_b1 = 4'hF; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("n1_busy", 32'(busy1), 32'd1);
    wait_valid1(lat);
    check("n1_latency", 32'(lat), 32'd1);
    check("n1_product", 32'(out_product1), 32'hE1);
    tick();
    check("n1_count", 32'(done_count1), 32'd1);

    rst_n1 = 1'b0;
    #1 rst_n1 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rexp = {4'h0, ra} * {4'h0, rb};
      check("n1_rand_ready", 32'(in_ready1), 32'd1);
      in_a1 = ra; in_b1 = rb; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      wait_valid1(lat);
      check("n1_rand_latency", 32'(lat), 32'd1);
      check("n1_rand_product", 32'(out_product1), 32'(rexp));
      tick();
    end
    check("n1_rand_count", 32'(done_count1), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
